// File: rtl/lcd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_pkg
// Brief    : Shared types and constants for the LCD SPI write scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } lcd_state_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam int CMD_BITS = 8;
    localparam int PIX_BITS = 16;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_shifter
// Brief    : Serializes one 8- or 16-bit unit MSB-first with SPI mode-0 timing.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_shifter
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [4:0]  i_nbits,
    input  logic        i_rs,
    input  logic [15:0] i_word,
    output logic        o_done,
    output logic        o_lcd_clk,
    output logic        o_lcd_cs,
    output logic        o_lcd_rs,
    output logic        o_lcd_data
);

    localparam logic [7:0] c_PH_LAST = 8'(CLK_DIV - 1);

    lcd_state_t  r_state;
    logic [7:0]  r_phase;
    logic [4:0]  r_bit;
    logic [14:0] r_shift;
    logic        r_sclk;
    logic        r_cs;
    logic        r_rs;
    logic        r_data;

    logic        w_ph_end;

    assign w_ph_end = (r_phase == c_PH_LAST);
    assign o_done   = (r_state == ST_GAP) && w_ph_end;

    assign o_lcd_clk  = r_sclk;
    assign o_lcd_cs   = r_cs;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_data = r_data;

    // r_bit holds the number of bits still to follow the one on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= 8'd0;
            r_bit   <= 5'd0;
            r_shift <= 15'd0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_rs    <= 1'b1;
            r_data  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_phase <= 8'd0;
                    if (i_start) begin
                        r_state <= ST_SETUP;
                        r_shift <= i_word[14:0];
                        r_bit   <= i_nbits - 5'd1;
                        r_cs    <= 1'b0;
                        r_rs    <= i_rs;
                        r_data  <= i_word[15];
                    end
                end
                ST_SETUP: begin
                    if (w_ph_end) begin
                        r_phase <= 8'd0;
                        r_state <= ST_SHIFT;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (!w_ph_end) begin
                        r_phase <= r_phase + 8'd1;
                    end else begin
                        r_phase <= 8'd0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            if (r_bit != 5'd0) begin
                                r_shift <= {r_shift[13:0], 1'b0};
                                r_data  <= r_shift[14];
                            end
                        end else if (r_bit == 5'd0) begin
                            r_state <= ST_GAP;
                            r_cs    <= 1'b1;
                            r_rs    <= 1'b1;
                            r_data  <= 1'b1;
                        end else begin
                            r_bit  <= r_bit - 5'd1;
                            r_sclk <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_ph_end) begin
                        r_phase <= 8'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_scheduler
// Brief    : Arbitrates command and pixel requesters onto one LCD SPI channel.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_scheduler
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int CMD_BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_data,
    input  logic        cmd_lock,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        busy,
    output logic        lcd_clk,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_data
);

    localparam int              c_SW         = $clog2(CMD_BURST_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(CMD_BURST_MAX);

    logic [c_SW-1:0] r_starve;
    logic            r_busy;

    logic            w_idle;
    logic            w_pix_sel;
    logic            w_pix_go;
    logic            w_cmd_go;
    logic            w_start;
    logic            w_done;
    logic [4:0]      w_nbits;
    logic            w_rs;
    logic [15:0]     w_word;

    // The pixel port wins only when commands are absent or have starved it.
    assign w_idle    = !r_busy && !reset;
    assign w_pix_sel = pix_valid && !cmd_lock &&
                       (!cmd_valid || (r_starve == c_STARVE_MAX));
    assign w_pix_go  = w_idle && w_pix_sel;
    assign w_cmd_go  = w_idle && cmd_valid && !w_pix_sel;
    assign w_start   = w_pix_go || w_cmd_go;

    assign cmd_ready = w_cmd_go;
    assign pix_ready = w_pix_go;
    assign busy      = r_busy;

    assign w_nbits = w_pix_go ? 5'(PIX_BITS) : 5'(CMD_BITS);
    assign w_rs    = w_pix_go ? RS_DATA : cmd_data[8];
    assign w_word  = w_pix_go ? pix_data : {cmd_data[7:0], 8'h00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_pix_go) begin
            r_starve <= '0;
        end else if (w_cmd_go) begin
            if (!pix_valid) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    lcd_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_nbits    (w_nbits),
        .i_rs       (w_rs),
        .i_word     (w_word),
        .o_done     (w_done),
        .o_lcd_clk  (lcd_clk),
        .o_lcd_cs   (lcd_cs),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_data (lcd_data)
    );

endmodule
`default_nettype wire
